audio_scheduler: RTL



---
 rtl/audio_scheduler.sv | 115 +++++++++++
 1 files changed

// File: rtl/audio_scheduler.sv
// audio_scheduler: song sequencer driving note_gen's left channel, plus a priority SFX arbiter that overrides the right channel.
module audio_scheduler #(
  parameter int          TICK_DIV  = 12500000,
  parameter int          SONG_LEN  = 64,
  parameter int          SFX_TICKS = 2,
  parameter logic [21:0] SFX0_DIV  = 22'd191571,
  parameter logic [21:0] SFX1_DIV  = 22'd151515,
  parameter logic [21:0] SFX2_DIV  = 22'd127551,
  parameter logic [21:0] SFX3_DIV  = 22'd95556,
  localparam int         AW        = $clog2(SONG_LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          play_toggle,
  input  logic          stop,
  input  logic          loop,
  input  logic [3:0]    sfx_req,
  input  logic [21:0]   song_note,
  output logic [AW-1:0] song_addr,
  output logic [21:0]   note_div_left,
  output logic [21:0]   note_div_right,
  output logic [1:0]    play_state,
  output logic          sfx_busy,
  output logic [3:0]    sfx_grant
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(SFX_TICKS + 1);
  typedef enum logic [1:0] {STOP = 2'b00, PLAY = 2'b01, PAUSE = 2'b10} state_t;
  state_t        state_q, state_d;
  logic [TW-1:0] tcnt_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    id_q, id_d, cand;
  logic [3:0]    grant_q, grant_d;
  logic [21:0]   left_q, right_q, right_d, music_div;
  logic          busy_q, busy_d, tick, last, accept;
  assign tick      = tcnt_q == TW'(TICK_DIV - 1);
  assign last      = addr_q == AW'(SONG_LEN - 1);
  assign music_div = (state_q == PLAY) ? song_note : 22'd1;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      STOP:  if (play_toggle && !stop) state_d = PLAY;
      PLAY: begin
        if (stop) begin
          state_d = STOP;
          addr_d  = '0;
        end else if (play_toggle) state_d = PAUSE;
        else if (tick) begin
          addr_d  = last ? '0 : addr_q + 1'b1;
          state_d = (last && !loop) ? STOP : PLAY;
        end
      end
      PAUSE: begin
        if (stop) begin
          state_d = STOP;
          addr_d  = '0;
        end else if (play_toggle) state_d = PLAY;
      end
      default: state_d = STOP;
    endcase
  end
  // Lower index wins; a busy effect is only displaced by a strictly higher-priority one.
  assign cand   = sfx_req[0] ? 2'd0 : sfx_req[1] ? 2'd1 : sfx_req[2] ? 2'd2 : 2'd3;
  assign accept = |sfx_req && (!busy_q || cand < id_q);
  always_comb begin
    busy_d  = busy_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    if (accept) begin
      busy_d  = 1'b1;
      id_d    = cand;
      cnt_d   = CW'(SFX_TICKS);
      grant_d = 4'b0001 << cand;
    end else if (busy_q && tick) begin
      cnt_d  = cnt_q - 1'b1;
      busy_d = cnt_q != CW'(1);
    end
  end
  assign right_d = !busy_d ? music_div :
                   id_d == 2'd0 ? SFX0_DIV :
                   id_d == 2'd1 ? SFX1_DIV :
                   id_d == 2'd2 ? SFX2_DIV : SFX3_DIV;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_q  <= '0;
      state_q <= STOP;
      addr_q  <= '0;
      left_q  <= 22'd1;
      right_q <= 22'd1;
      busy_q  <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
    end else begin
      tcnt_q  <= tick ? '0 : tcnt_q + 1'b1;
      state_q <= state_d;
      addr_q  <= addr_d;
      left_q  <= music_div;
      right_q <= right_d;
      busy_q  <= busy_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
    end
  end
  assign song_addr      = addr_q;
  assign note_div_left  = left_q;
  assign note_div_right = right_q;
  assign play_state     = state_q;
  assign sfx_busy       = busy_q;
  assign sfx_grant      = grant_q;
endmodule
